// File: rtl/if_stage_dual_if.sv
// if_stage_dual_if: instruction-memory fetch port (PC out, words at PC and PC+1 back)
//   addr   : word address presented to imem (= PC)
//   rdata0 : instruction word at addr
//   rdata1 : instruction word at addr+1, wrapping mod 2^AW
interface if_stage_dual_if #(parameter int AW = 8);
  logic [AW-1:0] addr;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  modport master(output addr, input rdata0, rdata1);
  modport slave(input addr, output rdata0, rdata1);
endinterface

// File: rtl/if_stage_dual.sv
// if_stage_dual: dual-issue fetch stage with IF/ID register, redirect/flush/stall handling and dual-issue counter
//   clk, btnc_i (async active-low reset), stall_i, flush_i + branch_target_i, jump + jump_dir
//   imem : fetch port, PC out and the two words at PC / PC+1 in
//   IF_ID_type_{i,j,r}, IF_ID_instruction_{i,j,r}, IF_ID_pc_o : registered bundle
//   dual_cnt_o : number of two-instruction bundles loaded
module if_stage_dual #(
  parameter int AW = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic btnc_i,
  input  logic stall_i,
  input  logic flush_i,
  input  logic [AW-1:0] branch_target_i,
  input  logic jump,
  input  logic [31:0] jump_dir,
  if_stage_dual_if.master imem,
  output logic IF_ID_type_i,
  output logic IF_ID_type_j,
  output logic IF_ID_type_r,
  output logic [31:0] IF_ID_instruction_i,
  output logic [31:0] IF_ID_instruction_j,
  output logic [31:0] IF_ID_instruction_r,
  output logic [AW-1:0] IF_ID_pc_o,
  output logic [31:0] dual_cnt_o
);
  typedef enum logic [1:0] {K_NOP, K_I, K_R, K_J} kind_t;
  function automatic kind_t kind(input logic [31:0] w);
    return w[31:26] == 6'b000010 ? K_J :
           (w[31:26] == 6'b000000 || w[31:26] == 6'b011100) ? (w == 32'd0 ? K_NOP : K_R) :
           (w[31:26] inside {6'b100011, 6'b101011, 6'b000100, 6'b000101}) ? K_I : K_NOP;
  endfunction
  function automatic logic is_br(input logic [31:0] w);
    return w[31:26] inside {6'b000100, 6'b000101};
  endfunction
  // {has_dest, reg}: R writes rd, lw writes rt, everything else writes nothing
  function automatic logic [5:0] dest(input logic [31:0] w);
    return kind(w) == K_R ? {1'b1, w[15:11]} : w[31:26] == 6'b100011 ? {1'b1, w[20:16]} : 6'd0;
  endfunction
  logic [AW-1:0] pc, step;
  logic [31:0] w0, w1, n_wi, n_wj, n_wr;
  kind_t k0, k1;
  logic [5:0] d0, d1;
  logic hazard, dual, solo, iss0, iss1, n_ti, n_tj, n_tr;
  logic unused_jump_hi;
  assign unused_jump_hi = ^jump_dir;
  assign imem.addr = pc;
  always_comb begin
    w0 = imem.rdata0;
    w1 = imem.rdata1;
    k0 = kind(w0);
    k1 = kind(w1);
    d0 = dest(w0);
    d1 = dest(w1);
    hazard = d0[5] && (d0[4:0] == w1[25:21] || d0[4:0] == w1[20:16] || (d1[5] && d1[4:0] == d0[4:0]));
    dual = ((k0 == K_R && k1 == K_I && !is_br(w1)) || (k0 == K_I && !is_br(w0) && k1 == K_R)) && !hazard;
    solo = k0 == K_J || is_br(w0);
    iss0 = k0 != K_NOP;
    iss1 = (k0 == K_NOP && k1 != K_NOP) || dual;
    // single step only when w0 issues alone and w1 is a real instruction still to be fetched
    step = (solo || (iss0 && !dual && k1 != K_NOP)) ? AW'(1) : AW'(2);
    n_ti = (iss0 && k0 == K_I) || (iss1 && k1 == K_I);
    n_tj = (iss0 && k0 == K_J) || (iss1 && k1 == K_J);
    n_tr = (iss0 && k0 == K_R) || (iss1 && k1 == K_R);
    n_wi = (iss0 && k0 == K_I) ? w0 : (iss1 && k1 == K_I) ? w1 : 32'd0;
    n_wj = (iss0 && k0 == K_J) ? w0 : (iss1 && k1 == K_J) ? w1 : 32'd0;
    n_wr = (iss0 && k0 == K_R) ? w0 : (iss1 && k1 == K_R) ? w1 : 32'd0;
  end
  always_ff @(posedge clk or negedge btnc_i) begin
    if (!btnc_i) begin
      pc <= RESET_PC;
      {IF_ID_type_i, IF_ID_type_j, IF_ID_type_r} <= '0;
      {IF_ID_instruction_i, IF_ID_instruction_j, IF_ID_instruction_r} <= '0;
      IF_ID_pc_o <= '0;
      dual_cnt_o <= '0;
    end else if (flush_i || (!stall_i && jump)) begin
      pc <= flush_i ? branch_target_i : jump_dir[AW-1:0];
      {IF_ID_type_i, IF_ID_type_j, IF_ID_type_r} <= '0;
      {IF_ID_instruction_i, IF_ID_instruction_j, IF_ID_instruction_r} <= '0;
      IF_ID_pc_o <= '0;
    end else if (!stall_i) begin
      pc <= pc + step;
      {IF_ID_type_i, IF_ID_type_j, IF_ID_type_r} <= {n_ti, n_tj, n_tr};
      {IF_ID_instruction_i, IF_ID_instruction_j, IF_ID_instruction_r} <= {n_wi, n_wj, n_wr};
      IF_ID_pc_o <= pc;
      dual_cnt_o <= dual_cnt_o + {31'd0, dual};
    end
  end
endmodule

// File: tb/tb_if_stage_dual.sv
// tb_if_stage_dual: scoreboard bench for if_stage_dual with a list-based bundle model
module tb_if_stage_dual;
  logic clk = 0, btnc_i = 0, stall_i = 0, flush_i = 0, jump = 0;
  logic [7:0] branch_target_i = 0;
  logic [31:0] jump_dir = 0;
  logic ti, tj, tr;
  logic [31:0] wi, wj, wr, cnt;
  logic [7:0] bpc, a1;
  logic [31:0] mem [256];
  if_stage_dual_if #(.AW(8)) imem();
  assign a1 = imem.addr + 8'd1;
  assign imem.rdata0 = mem[imem.addr];
  assign imem.rdata1 = mem[a1];
  always #5 clk = ~clk;
  if_stage_dual #(.AW(8), .RESET_PC(8'd0)) dut (
    .clk(clk), .btnc_i(btnc_i), .stall_i(stall_i), .flush_i(flush_i),
    .branch_target_i(branch_target_i), .jump(jump), .jump_dir(jump_dir), .imem(imem),
    .IF_ID_type_i(ti), .IF_ID_type_j(tj), .IF_ID_type_r(tr),
    .IF_ID_instruction_i(wi), .IF_ID_instruction_j(wj), .IF_ID_instruction_r(wr),
    .IF_ID_pc_o(bpc), .dual_cnt_o(cnt)
  );
  typedef struct {
    logic [7:0] pc;
    logic ti, tj, tr;
    logic [31:0] wi, wj, wr;
    logic [7:0] bpc;
    logic [31:0] cnt;
  } st_t;
  st_t m, e;
  st_t q[$];
  int pass = 0, total = 0;
  localparam logic [31:0] LW = 32'h8C220000, ADD = 32'h00642820, LW65 = 32'h8CA60000;
  localparam logic [31:0] SUB = 32'h00A63822, JMP = 32'h08000020;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a === x) pass++;
    else $display("FAIL %s got=%0h exp=%0h", n, a, x);
  endtask
  // kind: 0 nop, 1 I, 2 R, 3 J
  function automatic int kind(input logic [31:0] w);
    case (w[31:26])
      6'h02: return 3;
      6'h00, 6'h1C: return w == 0 ? 0 : 2;
      6'h23, 6'h2B, 6'h04, 6'h05: return 1;
      default: return 0;
    endcase
  endfunction
  function automatic bit br(input logic [31:0] w);
    return w[31:26] == 6'h04 || w[31:26] == 6'h05;
  endfunction
  function automatic int dst(input logic [31:0] w);
    if (kind(w) == 2) return int'(w[15:11]);
    if (w[31:26] == 6'h23) return int'(w[20:16]);
    return -1;
  endfunction
  task automatic bubble();
    {m.ti, m.tj, m.tr} = 0;
    {m.wi, m.wj, m.wr} = 0;
    m.bpc = 0;
  endtask
  task automatic model_step();
    logic [31:0] w0, w1;
    logic [7:0] p1;
    logic [31:0] iss[$];
    int k0, k1, d0, adv;
    bit pair;
    if (flush_i) begin m.pc = branch_target_i; bubble(); end
    else if (!stall_i && jump) begin m.pc = jump_dir[7:0]; bubble(); end
    else if (!stall_i) begin
      p1 = m.pc + 8'd1;
      w0 = mem[m.pc];
      w1 = mem[p1];
      k0 = kind(w0);
      k1 = kind(w1);
      if (k0 == 0) begin
        if (k1 != 0) iss.push_back(w1);
        adv = 2;
      end else if (k0 == 3 || br(w0)) begin
        iss.push_back(w0);
        adv = 1;
      end else begin
        pair = (k0 == 2 && k1 == 1 && !br(w1)) || (k0 == 1 && k1 == 2);
        d0 = dst(w0);
        if (d0 >= 0 && (d0 == int'(w1[25:21]) || d0 == int'(w1[20:16]) || d0 == dst(w1))) pair = 0;
        iss.push_back(w0);
        if (pair) iss.push_back(w1);
        adv = (pair || k1 == 0) ? 2 : 1;
      end
      bubble();
      foreach (iss[n]) begin
        case (kind(iss[n]))
          1: begin m.ti = 1; m.wi = iss[n]; end
          2: begin m.tr = 1; m.wr = iss[n]; end
          3: begin m.tj = 1; m.wj = iss[n]; end
          default: ;
        endcase
      end
      m.bpc = m.pc;
      m.pc = m.pc + 8'(adv);
      if (iss.size() == 2) m.cnt++;
    end
  endtask
  // entered at a negedge: drive, predict, push, wait for the following negedge
  task automatic cycle(input bit s, input bit f, input logic [7:0] t, input bit j, input logic [31:0] jd);
    stall_i = s;
    flush_i = f;
    branch_target_i = t;
    jump = j;
    jump_dir = jd;
    model_step();
    q.push_back(m);
    @(negedge clk);
  endtask
  function automatic logic [31:0] rnd_word();
    logic [4:0] rs, rt, rd;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1, 2: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      3: return {6'h1C, rs, rt, rd, 5'd0, 6'h02};
      4: return {6'h23, rs, rt, 16'($urandom)};
      5: return {6'h2B, rs, rt, 16'($urandom)};
      6: return {6'h04, rs, rt, 16'($urandom)};
      7: return {6'h05, rs, rt, 16'($urandom)};
      8: return {6'h02, 26'($urandom)};
      default: return {6'h08, rs, rt, 16'($urandom)};
    endcase
  endfunction
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_pc", imem.addr, e.pc);
        chk("sb_type_i", ti, e.ti);
        chk("sb_type_j", tj, e.tj);
        chk("sb_type_r", tr, e.tr);
        chk("sb_instr_i", wi, e.wi);
        chk("sb_instr_j", wj, e.wj);
        chk("sb_instr_r", wr, e.wr);
        chk("sb_if_pc", bpc, e.bpc);
        chk("sb_cnt", cnt, e.cnt);
      end
    end
  end
  initial begin
    foreach (mem[n]) mem[n] = 0;
    m = '{default: '0};
    #3;
    chk("rst_addr", imem.addr, 0);
    chk("rst_types", {ti, tj, tr}, 0);
    chk("rst_cnt", cnt, 0);
    @(negedge clk);
    btnc_i = 1;
    mem[0] = LW;
    mem[1] = ADD;
    cycle(0, 0, 0, 0, 0);
    chk("t1_types", {ti, tj, tr}, 3'b101);
    chk("t1_pc", imem.addr, 2);
    chk("t1_cnt", cnt, 1);
    cycle(0, 1, 0, 0, 0);
    mem[0] = ADD;
    mem[1] = LW65;
    mem[2] = 0;
    cycle(0, 0, 0, 0, 0);
    chk("t2_types", {ti, tj, tr}, 3'b001);
    chk("t2_pc", imem.addr, 1);
    cycle(0, 0, 0, 0, 0);
    chk("t2_lw", wi, LW65);
    chk("t2_cnt", cnt, 1);
    cycle(0, 1, 0, 0, 0);
    mem[1] = SUB;
    mem[2] = ADD;
    cycle(0, 0, 0, 0, 0);
    chk("t3_pc1", imem.addr, 1);
    cycle(0, 0, 0, 0, 0);
    chk("t3_pc2", imem.addr, 2);
    chk("t3_sub", wr, SUB);
    cycle(0, 1, 0, 0, 0);
    mem[0] = JMP;
    mem[1] = 0;
    mem[8'h20] = LW;
    mem[8'h21] = ADD;
    cycle(0, 0, 0, 0, 0);
    chk("t4_j", {ti, tj, tr}, 3'b010);
    cycle(0, 0, 0, 1, 32'h20);
    chk("t4_bubble", {ti, tj, tr}, 0);
    chk("t4_pc", imem.addr, 8'h20);
    cycle(0, 0, 0, 0, 0);
    chk("t4_dual", {ti, tr}, 2'b11);
    chk("t4_ifpc", bpc, 8'h20);
    repeat (3) begin
      cycle(1, 0, 0, 0, 0);
      chk("t5_hold_pc", imem.addr, 8'h22);
      chk("t5_hold_cnt", cnt, 2);
    end
    cycle(1, 1, 8'h40, 0, 0);
    chk("t5_flush_pc", imem.addr, 8'h40);
    chk("t5_flush_types", {ti, tj, tr}, 0);
    cycle(0, 1, 8'hFF, 0, 0);
    mem[8'hFF] = LW;
    mem[0] = ADD;
    cycle(0, 0, 0, 0, 0);
    chk("t6_wrap_pc", imem.addr, 1);
    chk("t6_ifpc", bpc, 8'hFF);
    chk("t6_cnt", cnt, 3);
    foreach (mem[n]) mem[n] = rnd_word();
    repeat (600)
      cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8, 8'($urandom),
            $urandom_range(0, 99) < 10, $urandom);
    chk("sb_drained", q.size(), 0);
    @(posedge clk);
    #2;
    btnc_i = 0;
    #1;
    chk("arst_pc", imem.addr, 0);
    chk("arst_types", {ti, tj, tr}, 0);
    chk("arst_instr", wi | wj | wr, 0);
    chk("arst_ifpc", bpc, 0);
    chk("arst_cnt", cnt, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
